// File: rtl/jam_permute_gen.sv
// Lexicographic next-permutation generator: holds N job indices and steps to the
// next permutation in lexicographic order through PIVOT, SWAP and REVERSE phases.
module jam_permute_gen #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          next,
  output logic [N*IW-1:0] perm,
  output logic          permute_valid,
  output logic          last
);

  // Handshake: perm is consumable whenever permute_valid=1. next is a request
  // with no ready of its own; it is only sampled while permute_valid=1 and is
  // ignored otherwise, including while an update is in flight.

  localparam logic [2:0] ST_INIT    = 3'd0;
  localparam logic [2:0] ST_HOLD    = 3'd1;
  localparam logic [2:0] ST_PIVOT   = 3'd2;
  localparam logic [2:0] ST_SWAP    = 3'd3;
  localparam logic [2:0] ST_REVERSE = 3'd4;

  logic [2:0]    state;
  logic [IW-1:0] p     [N];
  logic [IW-1:0] swap_p[N];
  logic [IW-1:0] rev_p [N];
  logic [IW-1:0] i_r, j_r;
  logic [IW-1:0] piv_i, piv_j, p_at_piv;
  logic          piv_found;
  logic [IW-1:0] p_i_val, p_j_val;

  // Pivot search: later matches overwrite earlier ones, leaving the largest index.
  always_comb begin
    piv_i     = '0;
    piv_found = 1'b0;
    for (int k = 0; k < N - 1; k++) begin
      if (p[k] < p[k+1]) begin
        piv_i     = IW'(k);
        piv_found = 1'b1;
      end
    end
    p_at_piv = '0;
    for (int k = 0; k < N; k++) begin
      if (IW'(k) == piv_i) p_at_piv = p[k];
    end
    piv_j = '0;
    for (int k = 0; k < N; k++) begin
      if ((IW'(k) > piv_i) && (p[k] > p_at_piv)) piv_j = IW'(k);
    end
  end

  always_comb begin
    p_i_val = '0;
    p_j_val = '0;
    for (int k = 0; k < N; k++) begin
      if (IW'(k) == i_r) p_i_val = p[k];
      if (IW'(k) == j_r) p_j_val = p[k];
    end
    for (int k = 0; k < N; k++) begin
      if (IW'(k) == i_r)      swap_p[k] = p_j_val;
      else if (IW'(k) == j_r) swap_p[k] = p_i_val;
      else                    swap_p[k] = p[k];
    end
  end

  // Suffix reversal: position k > i takes the element mirrored about the suffix centre.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      rev_p[k] = p[k];
      for (int s = 0; s < N; s++) begin
        if ((k > int'(i_r)) && (s == N + int'(i_r) - k)) rev_p[k] = p[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
      i_r   <= '0;
      j_r   <= '0;
      for (int k = 0; k < N; k++) p[k] <= IW'(k);
    end else begin
      case (state)
        ST_INIT: state <= ST_HOLD;
        ST_HOLD: begin
          if (next && piv_found) state <= ST_PIVOT;
        end
        ST_PIVOT: begin
          i_r   <= piv_i;
          j_r   <= piv_j;
          state <= ST_SWAP;
        end
        ST_SWAP: begin
          for (int k = 0; k < N; k++) p[k] <= swap_p[k];
          state <= ST_REVERSE;
        end
        ST_REVERSE: begin
          for (int k = 0; k < N; k++) p[k] <= rev_p[k];
          state <= ST_HOLD;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  always_comb begin
    perm = '0;
    for (int k = 0; k < N; k++) perm[IW*k +: IW] = p[k];
  end

  assign permute_valid = (state == ST_HOLD);
  assign last          = permute_valid && !piv_found;

endmodule
